soc_cluster_pwr_seq: RTL and testbench

SOC_CLUSTER_PWR_SEQ -- requirements
Module: soc_cluster_pwr_seq

---
 rtl/soc_cluster_pwr_seq_pkg.sv | 66 ++++++
 rtl/soc_cluster_pwr_seq_sync_2ff.sv | 22 ++
 rtl/soc_cluster_pwr_seq.sv | 173 +++++++++++++++++
 tb/tb_soc_cluster_pwr_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_cluster_pwr_seq_pkg.sv
// Shared SoC package for the cluster power sequencer: state encodings,
// default sequencing constants and the per-state output table.
package soc_cluster_pwr_seq_pkg;

  localparam int unsigned DEF_ISO_CYCLES     = 4;
  localparam int unsigned DEF_RST_CYCLES     = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  localparam int STATE_W = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    PS_OFF     = 4'd0,
    PS_PWR_UP  = 4'd1,
    PS_ISO_OFF = 4'd2,
    PS_CLK_ON  = 4'd3,
    PS_RUN     = 4'd4,
    PS_STOP    = 4'd5,
    PS_CLK_OFF = 4'd6,
    PS_ISO_ON  = 4'd7,
    PS_PWR_DN  = 4'd8
  } pwr_state_e;

  // Plain numeric copies of the encodings for legacy status decode.
  localparam logic [STATE_W-1:0] ST_OFF     = PS_OFF;
  localparam logic [STATE_W-1:0] ST_PWR_UP  = PS_PWR_UP;
  localparam logic [STATE_W-1:0] ST_ISO_OFF = PS_ISO_OFF;
  localparam logic [STATE_W-1:0] ST_CLK_ON  = PS_CLK_ON;
  localparam logic [STATE_W-1:0] ST_RUN     = PS_RUN;
  localparam logic [STATE_W-1:0] ST_STOP    = PS_STOP;
  localparam logic [STATE_W-1:0] ST_CLK_OFF = PS_CLK_OFF;
  localparam logic [STATE_W-1:0] ST_ISO_ON  = PS_ISO_ON;
  localparam logic [STATE_W-1:0] ST_PWR_DN  = PS_PWR_DN;

  typedef struct packed {
    logic pwr_en;
    logic iso;
    logic clk_en;
    logic rstn;
    logic fetch;
  } pwr_out_t;

  // Output pattern for a state; RUN passes the software reset/fetch through,
  // with fetch qualified by reset so the core never fetches while held.
  function automatic pwr_out_t state_outputs(input logic [STATE_W-1:0] st,
                                             input logic rstn_req,
                                             input logic fetch_req);
    pwr_out_t o;
    o = '{pwr_en: 1'b0, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
    case (st)
      ST_OFF:     o = '{pwr_en: 1'b0, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
      ST_PWR_UP:  o = '{pwr_en: 1'b1, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
      ST_ISO_OFF: o = '{pwr_en: 1'b1, iso: 1'b0, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
      ST_CLK_ON:  o = '{pwr_en: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: 1'b0, fetch: 1'b0};
      ST_RUN:     o = '{pwr_en: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: rstn_req,
                        fetch: fetch_req & rstn_req};
      ST_STOP:    o = '{pwr_en: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: 1'b0, fetch: 1'b0};
      ST_CLK_OFF: o = '{pwr_en: 1'b1, iso: 1'b0, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
      ST_ISO_ON:  o = '{pwr_en: 1'b1, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
      ST_PWR_DN:  o = '{pwr_en: 1'b0, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
      default:    o = '{pwr_en: 1'b0, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/soc_cluster_pwr_seq_sync_2ff.sv
// Two-flop synchronizer for the asynchronous power-switch acknowledge.
module soc_sync_2ff (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc_cluster_pwr_seq.sv
// Cluster power sequencer: brings the cluster power domain up and down in a
// fixed order (switch, isolation, clock, reset) with abort and ack timeout.
module soc_cluster_pwr_seq
  import soc_cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned ISO_CYCLES     = DEF_ISO_CYCLES,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               cluster_pow_i,
  input  logic               cluster_byp_i,
  input  logic               cluster_rstn_i,
  input  logic               cluster_fetch_enable_i,
  input  logic               pwr_ack_i,
  output logic               pwr_en_o,
  output logic               iso_o,
  output logic               clk_en_o,
  output logic               byp_o,
  output logic               cluster_rstn_o,
  output logic               fetch_en_o,
  output logic               busy_o,
  output logic               error_o,
  output logic [STATE_W-1:0] state_o
);

  // Counter is loaded with N-1 so that a zero count marks the Nth cycle.
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               cnt_zero;
  logic               ack_s;
  logic               timeout_hit;
  logic               err_nxt;
  logic               byp_nxt;
  pwr_out_t           out_nxt;

  // Reload value for the shared counter on entry to each state.
  function automatic logic [CNT_W-1:0] cnt_load(input logic [STATE_W-1:0] st);
    logic [CNT_W-1:0] v;
    case (st)
      ST_PWR_UP, ST_PWR_DN: v = TO_LD;
      ST_ISO_OFF, ST_ISO_ON: v = ISO_LD;
      ST_CLK_ON, ST_STOP:   v = RST_LD;
      default:              v = '0;
    endcase
    return v;
  endfunction

  soc_sync_2ff u_ack_sync (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .d       (pwr_ack_i),
    .q       (ack_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // Next-state decode; a power-request drop aborts power-up ahead of the
  // state's own transition, and is ignored once teardown has begun.
  always_comb begin
    state_nxt   = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (cluster_pow_i) state_nxt = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        if (!cluster_pow_i) begin
          state_nxt = ST_PWR_DN;
        end else if (ack_s) begin
          state_nxt = ST_ISO_OFF;
        end else if (cnt_zero) begin
          state_nxt   = ST_PWR_DN;
          timeout_hit = 1'b1;
        end
      end
      ST_ISO_OFF: begin
        if (!cluster_pow_i) state_nxt = ST_ISO_ON;
        else if (cnt_zero)  state_nxt = ST_CLK_ON;
      end
      ST_CLK_ON: begin
        if (!cluster_pow_i) state_nxt = ST_STOP;
        else if (cnt_zero)  state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!cluster_pow_i) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (cnt_zero) state_nxt = ST_CLK_OFF;
      end
      ST_CLK_OFF: begin
        if (cnt_zero) state_nxt = ST_ISO_ON;
      end
      ST_ISO_ON: begin
        if (cnt_zero) state_nxt = ST_PWR_DN;
      end
      ST_PWR_DN: begin
        if (!ack_s) begin
          state_nxt = ST_OFF;
        end else if (cnt_zero) begin
          state_nxt   = ST_OFF;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // Counter reloads on any state change, otherwise counts down to zero.
  always_comb begin
    cnt_nxt = cnt_q;
    if (state_nxt != state_q) begin
      cnt_nxt = cnt_load(state_nxt);
    end else if (!cnt_zero) begin
      cnt_nxt = cnt_q - 1'b1;
    end
  end

  // Output values for the state being entered, plus sticky error and the
  // clock select, which may only move while the clock is off on both sides
  // of the edge.
  always_comb begin
    out_nxt = state_outputs(state_nxt, cluster_rstn_i, cluster_fetch_enable_i);
    err_nxt = error_o;
    if (state_nxt == ST_PWR_UP && state_q != ST_PWR_UP) begin
      err_nxt = 1'b0;
    end else if (timeout_hit) begin
      err_nxt = 1'b1;
    end
    byp_nxt = byp_o;
    if (!clk_en_o && !out_nxt.clk_en) begin
      byp_nxt = cluster_byp_i;
    end
  end

  // State, counter and all outputs registered together so every output
  // changes on the edge that enters its state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= ST_OFF;
      cnt_q          <= '0;
      pwr_en_o       <= 1'b0;
      iso_o          <= 1'b1;
      clk_en_o       <= 1'b0;
      byp_o          <= 1'b1;
      cluster_rstn_o <= 1'b0;
      fetch_en_o     <= 1'b0;
      busy_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      cnt_q          <= cnt_nxt;
      pwr_en_o       <= out_nxt.pwr_en;
      iso_o          <= out_nxt.iso;
      clk_en_o       <= out_nxt.clk_en;
      byp_o          <= byp_nxt;
      cluster_rstn_o <= out_nxt.rstn;
      fetch_en_o     <= out_nxt.fetch;
      busy_o         <= (state_nxt != ST_OFF) && (state_nxt != ST_RUN);
      error_o        <= err_nxt;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_soc_cluster_pwr_seq.sv
// Testbench for soc_cluster_pwr_seq: cycle-level behavioural model with a
// per-cycle compare, plus directed scenarios with literal expectations.
module tb_soc_cluster_pwr_seq;

  localparam int ISO_N = 4;
  localparam int RST_N = 8;
  localparam int TO_N  = 1024;

  localparam int S_OFF = 0, S_PWR_UP = 1, S_ISO_OFF = 2, S_CLK_ON = 3, S_RUN = 4;
  localparam int S_STOP = 5, S_CLK_OFF = 6, S_ISO_ON = 7, S_PWR_DN = 8;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       cluster_pow_i = 1'b0;
  logic       cluster_byp_i = 1'b1;
  logic       cluster_rstn_i = 1'b0;
  logic       cluster_fetch_enable_i = 1'b0;
  logic       pwr_ack_i = 1'b0;
  logic       pwr_en_o, iso_o, clk_en_o, byp_o, cluster_rstn_o, fetch_en_o;
  logic       busy_o, error_o;
  logic [3:0] state_o;

  always #5 HCLK = ~HCLK;

  soc_cluster_pwr_seq dut (
    .HCLK                   (HCLK),
    .HRESETn                (HRESETn),
    .cluster_pow_i          (cluster_pow_i),
    .cluster_byp_i          (cluster_byp_i),
    .cluster_rstn_i         (cluster_rstn_i),
    .cluster_fetch_enable_i (cluster_fetch_enable_i),
    .pwr_ack_i              (pwr_ack_i),
    .pwr_en_o               (pwr_en_o),
    .iso_o                  (iso_o),
    .clk_en_o               (clk_en_o),
    .byp_o                  (byp_o),
    .cluster_rstn_o         (cluster_rstn_o),
    .fetch_en_o             (fetch_en_o),
    .busy_o                 (busy_o),
    .error_o                (error_o),
    .state_o                (state_o)
  );

  int checks = 0;
  int errors = 0;
  int prints = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      prints++;
    end
  endtask

  // Per-state output table {pwr_en, iso, clk_en}, indexed by state code.
  bit tbl_pwr [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  bit tbl_iso [9] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
  bit tbl_clk [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};

  int m_st = S_OFF;
  int m_t  = 1;
  bit m_pwr = 0, m_iso = 1, m_clk = 0, m_byp = 1, m_rstn = 0, m_fetch = 0;
  bit m_busy = 0, m_err = 0;
  bit h1 = 0, h2 = 0;

  // Model: m_t is the number of cycles spent so far in the current state.
  task automatic model_step();
    int nxt;
    bit e_set;
    bit syn;
    if (!HRESETn) begin
      m_st = S_OFF; m_t = 1;
      m_pwr = 0; m_iso = 1; m_clk = 0; m_byp = 1; m_rstn = 0; m_fetch = 0;
      m_busy = 0; m_err = 0; h1 = 0; h2 = 0;
      return;
    end
    syn = h2; h2 = h1; h1 = pwr_ack_i;
    nxt = m_st; e_set = 0;
    case (m_st)
      S_OFF:     if (cluster_pow_i) nxt = S_PWR_UP;
      S_PWR_UP:  if (!cluster_pow_i) nxt = S_PWR_DN;
                 else if (syn) nxt = S_ISO_OFF;
                 else if (m_t >= TO_N) begin nxt = S_PWR_DN; e_set = 1; end
      S_ISO_OFF: if (!cluster_pow_i) nxt = S_ISO_ON; else if (m_t >= ISO_N) nxt = S_CLK_ON;
      S_CLK_ON:  if (!cluster_pow_i) nxt = S_STOP; else if (m_t >= RST_N) nxt = S_RUN;
      S_RUN:     if (!cluster_pow_i) nxt = S_STOP;
      S_STOP:    if (m_t >= RST_N) nxt = S_CLK_OFF;
      S_CLK_OFF: if (m_t >= 1) nxt = S_ISO_ON;
      S_ISO_ON:  if (m_t >= ISO_N) nxt = S_PWR_DN;
      S_PWR_DN:  if (!syn) nxt = S_OFF;
                 else if (m_t >= TO_N) begin nxt = S_OFF; e_set = 1; end
      default:   nxt = S_OFF;
    endcase
    if (nxt == S_PWR_UP && m_st != S_PWR_UP) m_err = 0;
    else if (e_set) m_err = 1;
    if (!m_clk && !tbl_clk[nxt]) m_byp = cluster_byp_i;
    m_pwr   = tbl_pwr[nxt];
    m_iso   = tbl_iso[nxt];
    m_clk   = tbl_clk[nxt];
    m_rstn  = (nxt == S_RUN) && cluster_rstn_i;
    m_fetch = (nxt == S_RUN) && cluster_rstn_i && cluster_fetch_enable_i;
    m_busy  = !(nxt == S_OFF || nxt == S_RUN);
    m_t     = (nxt == m_st) ? m_t + 1 : 1;
    m_st    = nxt;
  endtask

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    model_step();
  end

  // Every-cycle compare of all outputs against the model.
  initial forever begin
    @(negedge HCLK);
    if (chk_en)
      chk("cycle_outputs",
          32'({pwr_en_o, iso_o, clk_en_o, byp_o, cluster_rstn_o, fetch_en_o,
               busy_o, error_o, state_o}),
          32'({m_pwr, m_iso, m_clk, m_byp, m_rstn, m_fetch, m_busy, m_err, 4'(m_st)}));
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
    #2;
  endtask

  task automatic wait_state(input string nm, input int code, input int maxc);
    int n = 0;
    while (state_o !== 4'(code) && n < maxc) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(state_o), 32'(code));
  endtask

  task automatic count_state(input int code, input int maxc, output int n);
    n = 0;
    while (state_o === 4'(code) && n < maxc) begin
      n++;
      cyc(1);
    end
  endtask

  task automatic wait_pwr_en(input int maxc);
    int n = 0;
    while (pwr_en_o !== 1'b1 && n < maxc) begin
      cyc(1);
      n++;
    end
    chk("pwr_en_rise", 32'(pwr_en_o), 32'd1);
  endtask

  localparam logic [11:0] RST_VEC = 12'b0_1_0_1_0_0_0_0_0000;

  initial begin
    int n;
    bit seen_clk;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("reset_vec", 32'({pwr_en_o, iso_o, clk_en_o, byp_o, cluster_rstn_o, fetch_en_o,
                          busy_o, error_o, state_o}), 32'(RST_VEC));
    HRESETn = 1'b1;
    cyc(2);

    // Power-up with ack 3 cycles after pwr_en.
    cluster_byp_i = 1'b0;
    cluster_rstn_i = 1'b1;
    cluster_fetch_enable_i = 1'b1;
    cluster_pow_i = 1'b1;
    wait_pwr_en(10);
    chk("pwrup_iso_held", 32'(iso_o), 32'd1);
    cyc(3);
    pwr_ack_i = 1'b1;
    wait_state("reach_iso_off", S_ISO_OFF, 20);
    chk("iso_off_iso", 32'(iso_o), 32'd0);
    chk("iso_off_clk", 32'(clk_en_o), 32'd0);
    count_state(S_ISO_OFF, 50, n);
    chk("iso_off_len", 32'(n), 32'd4);
    chk("clk_on_state", 32'(state_o), 32'(S_CLK_ON));
    chk("clk_on_clk", 32'(clk_en_o), 32'd1);
    chk("clk_on_rstn", 32'(cluster_rstn_o), 32'd0);
    count_state(S_CLK_ON, 50, n);
    chk("clk_on_len", 32'(n), 32'd8);
    chk("run_state", 32'(state_o), 32'(S_RUN));
    chk("run_rstn", 32'(cluster_rstn_o), 32'd1);
    chk("run_fetch", 32'(fetch_en_o), 32'd1);
    chk("run_busy", 32'(busy_o), 32'd0);
    chk("run_byp", 32'(byp_o), 32'd0);

    // Bypass toggle during RUN must not move byp_o.
    cluster_byp_i = 1'b1;
    cyc(3);
    chk("run_byp_hold", 32'(byp_o), 32'd0);

    // Power-down.
    cluster_pow_i = 1'b0;
    cyc(1);
    chk("stop_state", 32'(state_o), 32'(S_STOP));
    count_state(S_STOP, 50, n);
    chk("stop_len", 32'(n), 32'd8);
    chk("clk_off_state", 32'(state_o), 32'(S_CLK_OFF));
    chk("clk_off_byp", 32'(byp_o), 32'd0);
    count_state(S_CLK_OFF, 50, n);
    chk("clk_off_len", 32'(n), 32'd1);
    chk("iso_on_state", 32'(state_o), 32'(S_ISO_ON));
    chk("iso_on_byp", 32'(byp_o), 32'd1);
    count_state(S_ISO_ON, 50, n);
    chk("iso_on_len", 32'(n), 32'd4);
    chk("pwr_dn_state", 32'(state_o), 32'(S_PWR_DN));
    pwr_ack_i = 1'b0;
    wait_state("reach_off", S_OFF, 10);
    chk("off_busy", 32'(busy_o), 32'd0);
    chk("off_pwr_en", 32'(pwr_en_o), 32'd0);

    // Abort in the 2nd cycle of ISO_OFF.
    cluster_pow_i = 1'b1;
    wait_pwr_en(10);
    pwr_ack_i = 1'b1;
    wait_state("abort_iso_off", S_ISO_OFF, 20);
    cyc(1);
    cluster_pow_i = 1'b0;
    cyc(1);
    chk("abort_to_iso_on", 32'(state_o), 32'(S_ISO_ON));
    pwr_ack_i = 1'b0;
    seen_clk = 1'b0;
    n = 0;
    while (state_o !== 4'(S_OFF) && n < 40) begin
      seen_clk |= clk_en_o;
      cyc(1);
      n++;
    end
    chk("abort_off", 32'(state_o), 32'(S_OFF));
    chk("abort_no_clk", 32'(seen_clk), 32'd0);

    // Ack timeout.
    cluster_pow_i = 1'b1;
    wait_state("to_pwr_up", S_PWR_UP, 10);
    chk("to_err_clear", 32'(error_o), 32'd0);
    count_state(S_PWR_UP, 2000, n);
    chk("to_len", 32'(n), 32'd1024);
    chk("to_pwr_dn", 32'(state_o), 32'(S_PWR_DN));
    chk("to_err_set", 32'(error_o), 32'd1);
    cluster_pow_i = 1'b0;
    wait_state("to_off", S_OFF, 10);
    chk("to_err_sticky", 32'(error_o), 32'd1);
    cluster_pow_i = 1'b1;
    cyc(1);
    chk("re_pwr_up", 32'(state_o), 32'(S_PWR_UP));
    chk("re_err_clear", 32'(error_o), 32'd0);

    // Reset asserted in RUN.
    pwr_ack_i = 1'b1;
    wait_state("re_run", S_RUN, 100);
    HRESETn = 1'b0;
    #1;
    chk("rst_in_run", 32'({pwr_en_o, iso_o, clk_en_o, byp_o, cluster_rstn_o, fetch_en_o,
                           busy_o, error_o, state_o}), 32'(RST_VEC));
    cyc(2);
    cluster_pow_i = 1'b0;
    pwr_ack_i = 1'b0;
    HRESETn = 1'b1;
    cyc(3);
    chk("post_rst_off", 32'(state_o), 32'(S_OFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
